// File: rtl/frame_diff_pkg.sv
// Shared types and constants for the multi-channel frame-difference engine.
package frame_diff_pkg;

  typedef enum logic [1:0] {
    FD_ABS  = 2'd0,
    FD_BIN  = 2'd1,
    FD_MASK = 2'd2,
    FD_RSVD = 2'd3
  } fd_mode_e;

  localparam int FD_PIPE_LAT = 3;

endpackage

// File: rtl/frame_diff_absdiff.sv
// One channel of registered absolute difference |a - b|.
module frame_diff_absdiff #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              srst,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] d
);

  logic [DATA_W:0] diff;

  // The extra top bit is the borrow; when set, b > a and the operands are swapped.
  assign diff = {1'b0, a} - {1'b0, b};

  always_ff @(posedge clk) begin
    if (srst) begin
      d <= '0;
    end else begin
      d <= diff[DATA_W] ? (b - a) : diff[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/frame_diff_mc.sv
// Frame-difference engine: per-channel |cur-prev|, threshold on the channel maximum,
// per-frame output mode and a per-frame changed-pixel count.
module frame_diff_mc #(
  parameter int         NUM_CH     = 3,
  parameter int         DATA_W     = 8,
  parameter int         CNT_W      = 20,
  parameter logic [1:0] DEF_MODE   = 2'd0,
  parameter int         DEF_THRESH = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pre_img_vsync,
  input  logic                     pre_img_hsync,
  input  logic                     pre_img_valid,
  input  logic [NUM_CH*DATA_W-1:0] pre_img_data,
  input  logic [NUM_CH*DATA_W-1:0] pre_frame_img_data,
  input  logic [1:0]               cfg_mode,
  input  logic [DATA_W-1:0]        cfg_thresh,
  output logic                     post_img_vsync,
  output logic                     post_img_hsync,
  output logic                     post_img_valid,
  output logic [NUM_CH*DATA_W-1:0] post_img_data,
  output logic [CNT_W-1:0]         frame_diff_cnt,
  output logic                     frame_diff_cnt_valid
);
  import frame_diff_pkg::*;

  localparam int               PW      = NUM_CH * DATA_W;
  localparam int               LAT     = FD_PIPE_LAT;
  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  logic              vsync_in_reg;
  logic              vsync_rise;
  fd_mode_e          mode_reg;
  logic [DATA_W-1:0] thresh_reg;
  logic [LAT-1:0]    vsync_sr, hsync_sr, valid_sr;
  logic [PW-1:0]     d_s1, cur_s1, d_s2, cur_s2;
  logic [DATA_W-1:0] dmax;
  logic              changed_s2, changed_s3;
  logic [PW-1:0]     data_next, data_reg;
  logic              vsync_s3_reg, vsync_s3_rise;
  logic [CNT_W-1:0]  acc_reg, cnt_reg;
  logic              cnt_valid_reg, first_frame_reg;

  // Configuration only changes at a frame boundary so a frame is never mixed.
  assign vsync_rise = pre_img_vsync & ~vsync_in_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vsync_in_reg <= 1'b0;
      mode_reg     <= fd_mode_e'(DEF_MODE);
      thresh_reg   <= DATA_W'(DEF_THRESH);
    end else begin
      vsync_in_reg <= pre_img_vsync;
      if (vsync_rise) begin
        mode_reg   <= fd_mode_e'(cfg_mode);
        thresh_reg <= cfg_thresh;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vsync_sr <= '0;
      hsync_sr <= '0;
      valid_sr <= '0;
    end else begin
      vsync_sr <= {vsync_sr[LAT-2:0], pre_img_vsync};
      hsync_sr <= {hsync_sr[LAT-2:0], pre_img_hsync};
      valid_sr <= {valid_sr[LAT-2:0], pre_img_valid};
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      frame_diff_absdiff #(.DATA_W(DATA_W)) u_absdiff (
        .clk  (clk),
        .srst (rst_n),
        .a    (pre_img_data[gi*DATA_W +: DATA_W]),
        .b    (pre_frame_img_data[gi*DATA_W +: DATA_W]),
        .d    (d_s1[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  always_comb begin
    dmax = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (d_s1[k*DATA_W +: DATA_W] > dmax) dmax = d_s1[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    data_next = '0;
    if (valid_sr[1]) begin
      case (mode_reg)
        FD_BIN:  data_next = changed_s2 ? {PW{1'b1}} : '0;
        FD_MASK: data_next = changed_s2 ? cur_s2 : '0;
        default: data_next = d_s2;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur_s1     <= '0;
      d_s2       <= '0;
      cur_s2     <= '0;
      changed_s2 <= 1'b0;
      changed_s3 <= 1'b0;
      data_reg   <= '0;
    end else begin
      cur_s1     <= pre_img_data;
      d_s2       <= d_s1;
      cur_s2     <= cur_s1;
      changed_s2 <= valid_sr[0] & (dmax > thresh_reg);
      changed_s3 <= changed_s2;
      data_reg   <= data_next;
    end
  end

  // A changed pixel on the closing edge already belongs to the next frame.
  assign vsync_s3_rise = vsync_sr[LAT-1] & ~vsync_s3_reg;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      vsync_s3_reg    <= 1'b0;
      acc_reg         <= '0;
      cnt_reg         <= '0;
      cnt_valid_reg   <= 1'b0;
      first_frame_reg <= 1'b1;
    end else begin
      vsync_s3_reg  <= vsync_sr[LAT-1];
      cnt_valid_reg <= 1'b0;
      if (vsync_s3_rise) begin
        if (first_frame_reg) begin
          first_frame_reg <= 1'b0;
        end else begin
          cnt_reg       <= acc_reg;
          cnt_valid_reg <= 1'b1;
        end
        acc_reg <= changed_s3 ? CNT_W'(1) : '0;
      end else if (changed_s3 && acc_reg != ACC_MAX) begin
        acc_reg <= acc_reg + CNT_W'(1);
      end
    end
  end

  assign post_img_vsync       = vsync_sr[LAT-1];
  assign post_img_hsync       = hsync_sr[LAT-1];
  assign post_img_valid       = valid_sr[LAT-1];
  assign post_img_data        = data_reg;
  assign frame_diff_cnt       = cnt_reg;
  assign frame_diff_cnt_valid = cnt_valid_reg;

endmodule

// File: tb/tb_frame_diff_mc.sv
// Scoreboard bench for frame_diff_mc: a 20-bit and a saturating 8-bit counter instance share stimulus.
module tb_frame_diff_mc;
  import frame_diff_pkg::*;

  localparam int PW = 24;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          vs = 1'b0, hs = 1'b0, vl = 1'b0;
  logic [PW-1:0] cur = '0, prev = '0;
  logic [1:0]    mode = 2'd0;
  logic [7:0]    thresh = 8'h20;

  logic          post_vs, post_hs, post_vl, cnt_v;
  logic [PW-1:0] post_data;
  logic [19:0]   cnt;
  logic          post_vs_s, post_hs_s, post_vl_s, cnt_v_s;
  logic [PW-1:0] post_data_s;
  logic [7:0]    cnt_s;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [PW-1:0] data;
    int            at;
  } pix_t;

  pix_t pq[$];
  int   cq[$];
  int   cq_s[$];
  pix_t e;
  logic strobe_prev = 1'b0, strobe_prev_s = 1'b0;

  frame_diff_mc #(.NUM_CH(3), .DATA_W(8), .CNT_W(20)) dut (
    .clk(clk), .rst_n(rst_n), .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vl),
    .pre_img_data(cur), .pre_frame_img_data(prev), .cfg_mode(mode), .cfg_thresh(thresh),
    .post_img_vsync(post_vs), .post_img_hsync(post_hs), .post_img_valid(post_vl),
    .post_img_data(post_data), .frame_diff_cnt(cnt), .frame_diff_cnt_valid(cnt_v)
  );

  frame_diff_mc #(.NUM_CH(3), .DATA_W(8), .CNT_W(8)) dut_small (
    .clk(clk), .rst_n(rst_n), .pre_img_vsync(vs), .pre_img_hsync(hs), .pre_img_valid(vl),
    .pre_img_data(cur), .pre_frame_img_data(prev), .cfg_mode(mode), .cfg_thresh(thresh),
    .post_img_vsync(post_vs_s), .post_img_hsync(post_hs_s), .post_img_valid(post_vl_s),
    .post_img_data(post_data_s), .frame_diff_cnt(cnt_s), .frame_diff_cnt_valid(cnt_v_s)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One input cycle; valid pixels register their expected output 3 cycles later.
  task automatic step(input logic v, input logic vsy, input logic hsy,
                      input logic [PW-1:0] c, input logic [PW-1:0] p, input logic [PW-1:0] x);
    @(posedge clk); #1;
    vl = v; vs = vsy; hs = hsy; cur = c; prev = p;
    if (v && !rst_n) pq.push_back('{x, cyc + FD_PIPE_LAT});
    if (v) $display("pixel cyc=%0d cur=%06h prev=%06h expect=%06h", cyc, c, p, x);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic vsync_pulse(input int count, input bit strobe);
    if (strobe) begin
      cq.push_back(count);
      cq_s.push_back(count > 255 ? 255 : count);
    end
    idle(4);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    step(1'b0, 1'b1, 1'b0, '0, '0, '0);
    idle(6);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_vsync"}, {post_vs, post_vs_s}, 0);
    chk({tag, "_hsync"}, {post_hs, post_hs_s}, 0);
    chk({tag, "_valid"}, {post_vl, post_vl_s}, 0);
    chk({tag, "_data"}, {post_data, post_data_s}, 0);
    chk({tag, "_cnt"}, {cnt, cnt_s}, 0);
    chk({tag, "_strobe"}, {cnt_v, cnt_v_s}, 0);
  endtask

  // A stream frame: the first n_chg pixels differ fully, the rest are identical.
  task automatic stream_frame(input int n_px, input int n_chg);
    for (int i = 0; i < n_px; i++) begin
      if (i < n_chg) step(1'b1, 1'b0, (i % 100) == 0, 24'hFFFFFF, 24'h000000, 24'hFFFFFF);
      else           step(1'b1, 1'b0, (i % 100) == 0, 24'h101010, 24'h101010, 24'h000000);
    end
  endtask

  always @(negedge clk) begin
    if (post_vl) begin
      if (pq.size() == 0) begin
        chk("pix_unexpected", 1, 0);
      end else begin
        e = pq.pop_front();
        chk("pix_data", post_data, e.data);
        chk("pix_data_small", post_data_s, e.data);
        chk("pix_valid_small", post_vl_s, 1);
        chk("pix_latency", cyc, e.at);
      end
    end
  end

  always @(negedge clk) begin
    if (cnt_v) begin
      chk("strobe_width", strobe_prev, 0);
      if (cq.size() == 0) chk("strobe_unexpected", 1, 0);
      else chk("frame_cnt", cnt, cq.pop_front());
    end
    if (cnt_v_s) begin
      chk("strobe_width_small", strobe_prev_s, 0);
      if (cq_s.size() == 0) chk("strobe_unexpected_small", 1, 0);
      else chk("frame_cnt_small", cnt_s, cq_s.pop_front());
    end
    strobe_prev   <= cnt_v;
    strobe_prev_s <= cnt_v_s;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b0;

    // First vsync after reset only arms the statistics.
    vsync_pulse(0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 24'h8040FF, 24'h904000, 24'h1000FF);
    mode = 2'd1;
    vsync_pulse(1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 24'h505050, 24'h304F50, 24'h000000);
    step(1'b1, 1'b0, 1'b0, 24'h505050, 24'h2F5050, 24'hFFFFFF);
    mode = 2'd2;
    vsync_pulse(1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 24'h12AB34, 24'h12AB00, 24'h12AB34);
    step(1'b1, 1'b0, 1'b0, 24'h12AB34, 24'h12AB30, 24'h000000);
    mode = 2'd1;
    vsync_pulse(1, 1'b1);

    // Threshold rewritten mid-frame must wait for the next frame.
    for (int ln = 0; ln < 6; ln++) begin
      if (ln == 3) thresh = 8'hF0;
      for (int p = 0; p < 4; p++) step(1'b1, 1'b0, p == 0, 24'h808080, 24'h404040, 24'hFFFFFF);
      idle(2);
    end
    vsync_pulse(24, 1'b1);
    for (int p = 0; p < 8; p++) step(1'b1, 1'b0, p == 0, 24'h808080, 24'h404040, 24'h000000);

    // Reset for two cycles in the middle of an active line.
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 pq.delete();
    @(negedge clk);
    check_zero("midreset1");
    @(posedge clk); #1 rst_n = 1'b0; vl = 1'b0; mode = 2'd0; thresh = 8'd30;
    @(negedge clk);
    check_zero("midreset2");

    // Statistics restart: frame 1 is swallowed by the first-frame rule.
    step(1'b1, 1'b0, 1'b1, 24'h8040FF, 24'h904000, 24'h1000FF);
    stream_frame(1100, 999);
    vsync_pulse(0, 1'b0);
    stream_frame(1300, 1234);
    vsync_pulse(1234, 1'b1);
    stream_frame(400, 300);
    vsync_pulse(300, 1'b1);
    idle(10);

    chk("pix_queue_drained", pq.size(), 0);
    chk("cnt_queue_drained", cq.size(), 0);
    chk("cnt_queue_small_drained", cq_s.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_diff_mc.md
Name: frame_diff_mc

Overview:
Parametrised multi-channel frame-difference engine for the video-stream pipeline. It compares the current-frame pixel stream against a co-timed previous-frame stream (1 or 2 frames back, supplied externally).
- Outputs one of three results, selected per frame: absolute difference, binary motion mask, or motion-gated pass-through.
- Reports a per-frame count of changed pixels.
- Sits between the frame buffer read-out and downstream morphology or BMP capture.

Parameters:
NUM_CH, 3, number of colour channels per pixel
DATA_W, 8, bits per channel
CNT_W, 20, width of the changed-pixel counter; must cover the active pixel count
DEF_MODE, 2'd0, mode loaded at reset
DEF_THRESH, 30, threshold loaded at reset (DATA_W bits)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-high (1 = reset); name kept per port convention
pre_img_vsync  in  1  current-frame vsync, active-high
pre_img_hsync  in  1  current-frame hsync
pre_img_valid  in  1  current-frame pixel valid
pre_img_data  in  NUM_CH*DATA_W  current-frame pixel; channel k at [k*DATA_W +: DATA_W]
pre_frame_img_data  in  NUM_CH*DATA_W  previous-frame pixel, same cycle alignment as pre_img_data
cfg_mode  in  2  0=ABS, 1=BIN, 2=MASK, 3=reserved (treated as ABS)
cfg_thresh  in  DATA_W  motion threshold
post_img_vsync  out  1  vsync delayed by the pipeline latency
post_img_hsync  out  1  hsync delayed by the pipeline latency
post_img_valid  out  1  valid delayed by the pipeline latency
post_img_data  out  NUM_CH*DATA_W  result pixel
frame_diff_cnt  out  CNT_W  changed-pixel count of the last complete frame
frame_diff_cnt_valid  out  1  one-cycle strobe when frame_diff_cnt updates

Behaviour:
- Reset: all outputs 0; pipeline flushed; shadow mode = DEF_MODE; shadow thresh = DEF_THRESH; accumulator 0; first_frame flag set.
- Config shadowing: cfg_mode and cfg_thresh are sampled into shadow registers only on the cycle a pre_img_vsync rising edge is detected (registered edge detector). Mid-frame changes have no effect until the next frame.
- Pipeline latency is fixed at 3 cycles. vsync, hsync and valid are delayed through a 3-stage shift register, so post_* timing is the input timing shifted by 3.
  - S1: register both inputs. For each channel, d[k] = |cur[k] - prev[k]|, computed as a (DATA_W+1)-bit subtraction with a sign-selected swap; d[k] is registered, DATA_W bits.
  - S2: dmax = max over channels of d[k]. changed = valid_s2 & (dmax > thresh_shadow), a strict compare. Register d[], dmax, changed, and the current pixel.
  - S3: output mux.
    - ABS: channel k = d[k].
    - BIN: all channels = all-ones if changed, else 0.
    - MASK: current pixel if changed, else 0.
- When valid is 0 at S3, post_img_data = 0.
- Statistics:
  - The accumulator increments on each S3 cycle with changed=1 and saturates at 2^CNT_W-1.
  - On a rising edge of the delayed (S3) vsync: frame_diff_cnt <= accumulator, frame_diff_cnt_valid = 1 for one cycle, then the accumulator is cleared. If a changed pixel coincides with that edge, the accumulator loads 1 instead of 0.
  - The first vsync edge after reset only clears first_frame: no strobe, frame_diff_cnt stays 0.
- Reset asserted mid-frame: all outputs go to 0 on the next clk edge. After release, the pipeline refills from fresh inputs and statistics restart with the first_frame rule.
- hsync is not used functionally; it is only delayed.

Decomposition:
- Package frame_diff_pkg:
  - typedef enum logic [1:0] fd_mode_e {FD_ABS=0, FD_BIN=1, FD_MASK=2, FD_RSVD=3};
  - localparam FD_PIPE_LAT = 3.
- Sub-module frame_diff_absdiff: one channel, parameter DATA_W, registered |a-b|. Instantiated NUM_CH times in a generate loop.
- The top contains the sync delay line, max tree, compare, output mux, config shadow and statistics.

Test Plan:
- Reset: hold rst_n=1 for 2 cycles mid-active-line. Expect all post_* = 0, frame_diff_cnt = 0 and no strobe; after release, outputs track input 3 cycles later.
- ABS: cur=0x8040FF, prev=0x904000. Expect post_img_data=0x1000FF exactly 3 cycles after the input valid, with post_img_valid aligned.
- BIN, thresh=0x20:
  - cur=0x505050, prev=0x304F50 -> dmax=0x20, not greater -> 0x000000.
  - prev=0x2F5050 -> dmax=0x21 -> 0xFFFFFF.
- MASK, thresh=0x20:
  - cur=0x12AB34, prev=0x12AB00 -> 0x12AB34.
  - prev=0x12AB30 -> 0x000000.
- Shadow: in frame N, write cfg_thresh 0x20→0xF0 at line 100. Frame N stays on 0x20; frame N+1 uses 0xF0.
- Stats, 800x600 stream:
  - Frame 1 has 1000 changed pixels: no strobe at frame 1's closing edge (first_frame).
  - Frame 2 has 1234 changed pixels: frame_diff_cnt=1234 with a one-cycle strobe.
  - With CNT_W=8 and 300 changed pixels: frame_diff_cnt=255.
